if_pipe_reg: RTL and testbench

Parametrised successor to the IF/ID stage register. Carries a PC/instruction pair between pipeline stages with a valid/ready handshake, freeze (stall) and flush. Flushed or empty slots present a configurable NOP. An optional two-entry skid buffer decouples the upstream ready from the downstream ready. Sits between IF and ID, and is reusable at any stage boundary by width parameters.

---
 rtl/if_pipe_pkg.sv | 22 ++
 rtl/if_pipe_reg_if.sv | 29 ++
 rtl/if_pipe_slot.sv | 29 ++
 rtl/if_pipe_reg.sv | 169 ++++++++++++++++
 tb/tb_if_pipe_reg.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/if_pipe_pkg.sv
// Shared types and constants for pipeline stage registers.
package if_pipe_pkg;

  // ARM MOV R0,R0: default bubble for ID-facing instances
  localparam logic [31:0] NOP_ARM = 32'hE1A00000;

  localparam int unsigned OCC_W = 2;

  // Occupancy doubles as the skid FSM state
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } occ_e;

  // PC/instruction beat at the default 32/32 widths
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } beat_t;

endpackage

// File: rtl/if_pipe_reg_if.sv
// Valid/ready beat bus between two pipeline stages, seen from both sides.
interface if_pipe_reg_if #(
  parameter int unsigned PC_W    = 32,
  parameter int unsigned INSTR_W = 32
);

  logic               in_valid;
  logic               in_ready;
  logic [PC_W-1:0]    in_pc;
  logic [INSTR_W-1:0] in_instr;
  logic               out_valid;
  logic               out_ready;
  logic [PC_W-1:0]    out_pc;
  logic [INSTR_W-1:0] out_instr;
  logic [1:0]         occupancy;

  // Environment side: drives upstream beats and downstream ready
  modport master (
    output in_valid, in_pc, in_instr, out_ready,
    input  in_ready, out_valid, out_pc, out_instr, occupancy
  );

  // Stage register side
  modport slave (
    input  in_valid, in_pc, in_instr, out_ready,
    output in_ready, out_valid, out_pc, out_instr, occupancy
  );

endinterface

// File: rtl/if_pipe_slot.sv
// Single payload register with load, synchronous clear and a reset/clear value.
module if_pipe_slot #(
  parameter int unsigned   W       = 64,
  parameter logic [W-1:0]  RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic         i_clear,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  // Clear wins over load; both return the slot to its empty value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= RST_VAL;
    end else if (i_clear) begin
      r_q <= RST_VAL;
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/if_pipe_reg.sv
// Pipeline stage register for PC/instruction beats with freeze, flush and
// an optional two-entry skid buffer.
module if_pipe_reg
  import if_pipe_pkg::*;
#(
  parameter int unsigned        PC_W      = 32,
  parameter int unsigned        INSTR_W   = 32,
  parameter logic [INSTR_W-1:0] NOP_INSTR = '0,
  parameter bit                 SKID      = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          freeze,
  input  logic          flush,
  if_pipe_reg_if.slave  bus
);

  localparam int unsigned         BEAT_W     = PC_W + INSTR_W;
  localparam logic [BEAT_W-1:0]   EMPTY_BEAT = {PC_W'(0), NOP_INSTR};

  logic [BEAT_W-1:0] w_in_beat;
  logic [BEAT_W-1:0] w_main_q;
  logic [BEAT_W-1:0] w_main_d;
  logic [BEAT_W-1:0] w_drain_beat;
  logic              w_main_load;
  logic              w_in_ready;
  logic              w_out_valid;
  logic              w_in_xfer;
  logic              w_out_xfer;
  logic [OCC_W-1:0]  w_occ;

  assign w_in_beat    = {bus.in_pc, bus.in_instr};
  // Draining the output keeps the last PC visible but shows the bubble
  assign w_drain_beat = {w_main_q[BEAT_W-1:INSTR_W], NOP_INSTR};
  assign w_in_xfer    = bus.in_valid & w_in_ready;
  assign w_out_xfer   = w_out_valid & bus.out_ready & ~freeze;

  // Output-facing entry; its contents are the stage outputs
  if_pipe_slot #(
    .W       (BEAT_W),
    .RST_VAL (EMPTY_BEAT)
  ) u_main (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_main_load),
    .i_clear (flush),
    .i_d     (w_main_d),
    .o_q     (w_main_q)
  );

  generate
    if (SKID) begin : g_skid
      occ_e              r_state;
      occ_e              w_state_nxt;
      logic              w_skid_load;
      logic [BEAT_W-1:0] w_skid_q;

      // Overflow entry that catches the beat in flight when downstream stalls
      if_pipe_slot #(
        .W       (BEAT_W),
        .RST_VAL ('0)
      ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_skid_load),
        .i_clear (flush),
        .i_d     (w_in_beat),
        .o_q     (w_skid_q)
      );

      // Occupancy state register
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_state <= ST_EMPTY;
        end else begin
          r_state <= w_state_nxt;
        end
      end

      // Next occupancy and slot load controls; flush empties both slots
      always_comb begin
        w_state_nxt = r_state;
        w_main_load = 1'b0;
        w_main_d    = w_in_beat;
        w_skid_load = 1'b0;
        if (flush) begin
          w_state_nxt = ST_EMPTY;
        end else begin
          case (r_state)
            ST_EMPTY: begin
              if (w_in_xfer) begin
                w_main_load = 1'b1;
                w_state_nxt = ST_ONE;
              end
            end
            ST_ONE: begin
              if (w_in_xfer && w_out_xfer) begin
                w_main_load = 1'b1;
              end else if (w_out_xfer) begin
                w_main_load = 1'b1;
                w_main_d    = w_drain_beat;
                w_state_nxt = ST_EMPTY;
              end else if (w_in_xfer) begin
                w_skid_load = 1'b1;
                w_state_nxt = ST_TWO;
              end
            end
            ST_TWO: begin
              if (w_out_xfer) begin
                w_main_load = 1'b1;
                w_main_d    = w_skid_q;
                w_state_nxt = ST_ONE;
              end
            end
            default: begin
              w_state_nxt = ST_EMPTY;
            end
          endcase
        end
      end

      // Ready depends only on held state and freeze, never on out_ready
      assign w_in_ready  = (r_state != ST_TWO) & ~freeze;
      assign w_out_valid = (r_state != ST_EMPTY);
      assign w_occ       = OCC_W'(r_state);
    end else begin : g_single
      logic r_valid;

      // Single-entry valid flag
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_valid <= 1'b0;
        end else if (flush) begin
          r_valid <= 1'b0;
        end else if (w_in_xfer) begin
          r_valid <= 1'b1;
        end else if (w_out_xfer) begin
          r_valid <= 1'b0;
        end
      end

      // Main slot load: replace on accept, show the bubble on drain
      always_comb begin
        w_main_load = 1'b0;
        w_main_d    = w_in_beat;
        if (!flush) begin
          if (w_in_xfer) begin
            w_main_load = 1'b1;
          end else if (w_out_xfer) begin
            w_main_load = 1'b1;
            w_main_d    = w_drain_beat;
          end
        end
      end

      // Accepts into a slot that is empty or draining this cycle
      assign w_in_ready  = (~r_valid | bus.out_ready) & ~freeze;
      assign w_out_valid = r_valid;
      assign w_occ       = {1'b0, r_valid};
    end
  endgenerate

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_pc    = w_main_q[BEAT_W-1:INSTR_W];
  assign bus.out_instr = w_main_q[INSTR_W-1:0];
  assign bus.occupancy = w_occ;

endmodule

// File: tb/tb_if_pipe_reg.sv
// Directed bench for if_pipe_reg: one skid instance and one single-register instance.
module tb_if_pipe_reg;
  import if_pipe_pkg::*;

  localparam logic [31:0] NOP_B = 32'h0000_0013;

  logic clk;
  logic rst_n;
  logic freeze;
  logic flush;

  int n_checks;
  int n_errors;

  if_pipe_reg_if #(.PC_W(32), .INSTR_W(32)) a_if ();
  if_pipe_reg_if #(.PC_W(32), .INSTR_W(32)) b_if ();

  if_pipe_reg #(
    .PC_W      (32),
    .INSTR_W   (32),
    .NOP_INSTR (NOP_ARM),
    .SKID      (1'b1)
  ) u_dut_skid (
    .clk    (clk),
    .rst_n  (rst_n),
    .freeze (freeze),
    .flush  (flush),
    .bus    (a_if.slave)
  );

  if_pipe_reg #(
    .PC_W      (32),
    .INSTR_W   (32),
    .NOP_INSTR (NOP_B),
    .SKID      (1'b0)
  ) u_dut_single (
    .clk    (clk),
    .rst_n  (rst_n),
    .freeze (freeze),
    .flush  (flush),
    .bus    (b_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input beat_t b);
    a_if.in_valid = v;
    a_if.in_pc    = b.pc;
    a_if.in_instr = b.instr;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    freeze   = 1'b0;
    flush    = 1'b0;
    drive_a(1'b0, '0);
    a_if.out_ready = 1'b0;
    b_if.in_valid  = 1'b0;
    b_if.in_pc     = '0;
    b_if.in_instr  = '0;
    b_if.out_ready = 1'b0;

    // Reset state
    #12;
    chk("rst_a_valid", 64'(a_if.out_valid), 64'd0);
    chk("rst_a_instr", 64'(a_if.out_instr), 64'(NOP_ARM));
    chk("rst_a_pc",    64'(a_if.out_pc),    64'd0);
    chk("rst_a_occ",   64'(a_if.occupancy), 64'd0);
    chk("rst_a_ready", 64'(a_if.in_ready),  64'd1);
    chk("rst_b_instr", 64'(b_if.out_instr), 64'(NOP_B));
    chk("rst_b_ready", 64'(b_if.in_ready),  64'd1);
    #5;
    rst_n = 1'b1;

    // Streaming four beats with out_ready held high
    a_if.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_a(1'b1, '{pc: 32'(4 * i), instr: 32'h0000_00A0 + 32'(i)});
      tick();
      chk("strm_valid", 64'(a_if.out_valid), 64'd1);
      chk("strm_pc",    64'(a_if.out_pc),    64'(4 * i));
      chk("strm_instr", 64'(a_if.out_instr), 64'(32'h0000_00A0 + 32'(i)));
      chk("strm_occ",   64'(a_if.occupancy), 64'd1);
    end
    drive_a(1'b0, '0);
    tick();
    chk("strm_empty_valid", 64'(a_if.out_valid), 64'd0);
    chk("strm_empty_instr", 64'(a_if.out_instr), 64'(NOP_ARM));
    chk("strm_empty_pc",    64'(a_if.out_pc),    64'h0C);

    // Backpressure absorbed by the skid entry
    a_if.out_ready = 1'b0;
    drive_a(1'b1, '{pc: 32'h10, instr: 32'hB0});
    tick();
    chk("bp_first_pc", 64'(a_if.out_pc), 64'h10);
    drive_a(1'b1, '{pc: 32'h14, instr: 32'hB1});
    tick();
    chk("bp_occ2",    64'(a_if.occupancy), 64'd2);
    chk("bp_ready0",  64'(a_if.in_ready),  64'd0);
    chk("bp_hold_pc", 64'(a_if.out_pc),    64'h10);
    drive_a(1'b0, '0);
    a_if.out_ready = 1'b1;
    tick();
    chk("bp_second_pc",    64'(a_if.out_pc),    64'h14);
    chk("bp_second_instr", 64'(a_if.out_instr), 64'hB1);
    chk("bp_occ1",         64'(a_if.occupancy), 64'd1);
    chk("bp_ready1",       64'(a_if.in_ready),  64'd1);
    tick();
    chk("bp_drained", 64'(a_if.out_valid), 64'd0);

    // Freeze holds everything while out_ready and in_valid are asserted
    a_if.out_ready = 1'b0;
    drive_a(1'b1, '{pc: 32'h20, instr: 32'hC0});
    tick();
    freeze = 1'b1;
    a_if.out_ready = 1'b1;
    drive_a(1'b1, '{pc: 32'h24, instr: 32'hC1});
    #1;
    chk("frz_ready_now", 64'(a_if.in_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("frz_pc",    64'(a_if.out_pc),    64'h20);
      chk("frz_instr", 64'(a_if.out_instr), 64'hC0);
      chk("frz_occ",   64'(a_if.occupancy), 64'd1);
      chk("frz_ready", 64'(a_if.in_ready),  64'd0);
    end
    freeze = 1'b0;
    #1;
    chk("frz_rel_ready", 64'(a_if.in_ready), 64'd1);
    tick();
    chk("frz_rel_pc",    64'(a_if.out_pc),    64'h24);
    chk("frz_rel_instr", 64'(a_if.out_instr), 64'hC1);
    drive_a(1'b0, '0);
    tick();
    chk("frz_rel_empty", 64'(a_if.occupancy), 64'd0);

    // Flush in TWO together with freeze and an offered beat
    a_if.out_ready = 1'b0;
    drive_a(1'b1, '{pc: 32'h30, instr: 32'hD0});
    tick();
    drive_a(1'b1, '{pc: 32'h34, instr: 32'hD1});
    tick();
    chk("fl_pre_occ", 64'(a_if.occupancy), 64'd2);
    flush  = 1'b1;
    freeze = 1'b1;
    drive_a(1'b1, '{pc: 32'h38, instr: 32'hD2});
    tick();
    chk("fl_occ",   64'(a_if.occupancy), 64'd0);
    chk("fl_valid", 64'(a_if.out_valid), 64'd0);
    chk("fl_instr", 64'(a_if.out_instr), 64'(NOP_ARM));
    chk("fl_pc",    64'(a_if.out_pc),    64'd0);
    flush  = 1'b0;
    freeze = 1'b0;
    drive_a(1'b0, '0);
    #1;
    chk("fl_ready", 64'(a_if.in_ready), 64'd1);
    tick();
    chk("fl_dropped", 64'(a_if.out_valid), 64'd0);

    // Single-register build: combinational ready and same-edge replacement
    b_if.out_ready = 1'b0;
    b_if.in_valid  = 1'b1;
    b_if.in_pc     = 32'h40;
    b_if.in_instr  = 32'hE0;
    #1;
    chk("s0_ready_empty", 64'(b_if.in_ready), 64'd1);
    tick();
    chk("s0_first_pc", 64'(b_if.out_pc),    64'h40);
    chk("s0_occ",      64'(b_if.occupancy), 64'd1);
    b_if.in_pc    = 32'h44;
    b_if.in_instr = 32'hE1;
    #1;
    chk("s0_ready_full", 64'(b_if.in_ready), 64'd0);
    tick();
    chk("s0_hold_pc", 64'(b_if.out_pc), 64'h40);
    b_if.out_ready = 1'b1;
    #1;
    chk("s0_ready_drain", 64'(b_if.in_ready), 64'd1);
    tick();
    chk("s0_repl_pc",    64'(b_if.out_pc),    64'h44);
    chk("s0_repl_instr", 64'(b_if.out_instr), 64'hE1);
    chk("s0_repl_occ",   64'(b_if.occupancy), 64'd1);
    b_if.in_valid = 1'b0;
    tick();
    chk("s0_empty_valid", 64'(b_if.out_valid), 64'd0);
    chk("s0_empty_instr", 64'(b_if.out_instr), 64'(NOP_B));
    chk("s0_empty_pc",    64'(b_if.out_pc),    64'h44);

    // Asynchronous reset mid-cycle clears the stage immediately
    a_if.out_ready = 1'b0;
    drive_a(1'b1, '{pc: 32'h50, instr: 32'hF0});
    tick();
    chk("ar_loaded", 64'(a_if.out_valid), 64'd1);
    drive_a(1'b0, '0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", 64'(a_if.out_valid), 64'd0);
    chk("ar_pc",    64'(a_if.out_pc),    64'd0);
    chk("ar_instr", 64'(a_if.out_instr), 64'(NOP_ARM));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
